// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stage registers.
//   skid_state_e    : occupancy state of a two-entry skid stage
//   NOP_INSN        : RV32I canonical NOP (ADDI x0,x0,0), the default bubble payload
//   *_bundle_t      : packed stage bundles; instantiate a stage with DATA_W = $bits(bundle)
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  // IF/ID bundle: instruction word plus the PC it was fetched from.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_bundle_t;

  // ID/EX bundle: decoded operands plus a small control field.
  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  ctrl;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
  } id_ex_bundle_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for stage performance monitoring.
//   clk   : clock, rising edge
//   rst   : synchronous reset, active-high, clears the count
//   inc   : count this cycle
//   count : current value; sticks at all-ones instead of wrapping
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a two-entry skid buffer.
//
// Handshake: a word moves across an interface on a rising edge where its
// valid and ready are both high (acc upstream, take downstream). Once valid
// is raised the payload is held stable until taken. o_in_rdy and o_out_vld
// both come straight from the state register, so back-pressure never forms a
// combinational path from i_out_rdy to o_in_rdy.
//
// Ports:
//   i_clk, i_rst        : clock (rising edge), synchronous active-high reset
//   i_flush             : drop both entries and same-cycle input, insert bubble
//   i_in_vld / o_in_rdy / i_in_data    : upstream side
//   o_out_vld / i_out_rdy / o_out_data : downstream side (o_out_data = main)
//   o_occupancy         : entries held (0..2), mirrors the FSM state
//   o_stall_cnt         : saturating count of o_out_vld & !i_out_rdy cycles
//   o_flush_cnt         : saturating count of i_flush cycles
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] BUBBLE_VAL = DATA_W'(NOP_INSN),
  parameter logic [DATA_W-1:0] FLUSH_MASK = '1,
  parameter int                CNT_W      = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_flush,
  input  logic              i_in_vld,
  output logic              o_in_rdy,
  input  logic [DATA_W-1:0] i_in_data,
  output logic              o_out_vld,
  input  logic              i_out_rdy,
  output logic [DATA_W-1:0] o_out_data,
  output logic [1:0]        o_occupancy,
  output logic [CNT_W-1:0]  o_stall_cnt,
  output logic [CNT_W-1:0]  o_flush_cnt
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              acc, take;
  logic              load_main_in, load_main_skid, load_skid_in;

  assign o_in_rdy   = (state_q != FULL);
  assign o_out_vld  = (state_q != EMPTY);
  assign o_out_data = main_q;
  assign acc        = i_in_vld & o_in_rdy;
  assign take       = o_out_vld & i_out_rdy;

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= EMPTY;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid_in   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (acc) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (acc && take) begin
          load_main_in = 1'b1;
        end else if (acc) begin
          load_skid_in = 1'b1;
          state_d      = FULL;
        end else if (take) begin
          // Main keeps its last payload; only the valid drops.
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (take) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush overrides every handshake move; the input is simply not captured.
    if (i_flush) begin
      state_d        = EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid_in   = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      main_q <= BUBBLE_VAL;
      skid_q <= BUBBLE_VAL;
    end else if (i_flush) begin
      // Masked bits become the bubble; unmasked bits (e.g. PC) keep their value.
      main_q <= (main_q & ~FLUSH_MASK) | (BUBBLE_VAL & FLUSH_MASK);
    end else begin
      if (load_main_in)   main_q <= i_in_data;
      if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)   skid_q <= i_in_data;
    end
  end

  always_comb begin
    o_occupancy = 2'd0;
    case (state_q)
      ONE:     o_occupancy = 2'd1;
      FULL:    o_occupancy = 2'd2;
      default: o_occupancy = 2'd0;
    endcase
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (o_out_vld & ~i_out_rdy),
    .count (o_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (i_flush),
    .count (o_flush_cnt)
  );

endmodule
